// File: rtl/risc_pkg.sv
// -----------------------------------------------------------------------------
// risc_pkg
// Shared definitions for the 16-bit RISC core front end.
//   INSTR_W / ADDR_W   : instruction and byte-address widths
//   OP_*               : major opcode values (instr[15:12])
//   fetch_state_e      : fetch unit FSM encoding
//   fetch_entry_t      : one fetched instruction with its address
//   pc_next()          : sequential PC step (16-bit modulo)
//   opcode_of()        : opcode field extraction
// -----------------------------------------------------------------------------
package risc_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;

    localparam logic [3:0] OP_LW  = 4'd0;
    localparam logic [3:0] OP_SW  = 4'd1;
    localparam logic [3:0] OP_BEQ = 4'd11;
    localparam logic [3:0] OP_BNE = 4'd12;
    localparam logic [3:0] OP_J   = 4'd13;

    // Instructions are 2 bytes wide, so sequential fetch steps by 2.
    localparam logic [ADDR_W-1:0] PC_STEP = 16'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

    // Wraps naturally at the top of the address space (FFFE -> 0000).
    function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

    function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: 4];
    endfunction

endpackage : risc_pkg

// File: rtl/fetch_skid_buffer.sv
// -----------------------------------------------------------------------------
// fetch_skid_buffer
// Single-entry holding register for an instruction that returned from memory
// while decode was stalled and the output register was already occupied.
//   clk, rst    : clock, synchronous active-high reset
//   load        : capture in_entry and mark the buffer full
//   clear       : empty the buffer (wins over load)
//   in_entry    : instruction + address to capture
//   full        : buffer holds a live instruction
//   out_entry   : buffered instruction + address
// -----------------------------------------------------------------------------
module fetch_skid_buffer
    import risc_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  fetch_entry_t in_entry,
    output logic         full,
    output fetch_entry_t out_entry
);

    logic         full_q,  full_d;
    fetch_entry_t entry_q, entry_d;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        full_d  = full_q;
        entry_d = entry_q;
        if (clear) begin
            full_d = 1'b0;
        end else if (load) begin
            full_d  = 1'b1;
            entry_d = in_entry;
        end
    end

    // NOTE: non-blocking assignments make every flop sample the values that
    // existed before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q  <= 1'b0;
            entry_q <= '0;
        end else begin
            full_q  <= full_d;
            entry_q <= entry_d;
        end
    end

    assign full      = full_q;
    assign out_entry = entry_q;

endmodule : fetch_skid_buffer

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: issues sequential reads to instruction memory,
// presents each returned instruction to decode through an output register,
// absorbs one in-flight instruction in a skid buffer when decode stalls,
// and restarts at a new address on redirect.
//   RESET_PC     : first fetch address after reset
//   clk, rst     : clock, synchronous active-high reset
//   imem_req     : memory read request (registered)
//   imem_addr    : byte address of the request, stable until ready/redirect
//   imem_ready   : imem_rdata valid this cycle, completes the request
//   imem_rdata   : returned instruction
//   stall        : decode cannot accept; hold the output register
//   redirect     : taken branch/jump downstream, restart at redirect_pc
//   redirect_pc  : new fetch address
//   if_valid     : output register holds a live instruction
//   if_instr     : fetched instruction
//   if_opcode    : if_instr[15:12]
//   if_pc_plus2  : if_pc + 2
//   if_pc        : address of if_instr
// -----------------------------------------------------------------------------
module fetch_unit
    import risc_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [3:0]         if_opcode,
    output logic [ADDR_W-1:0]  if_pc_plus2,
    output logic [ADDR_W-1:0]  if_pc
);

    fetch_state_e      state_q,     state_d;
    logic [ADDR_W-1:0] pc_q,        pc_d;
    logic              out_valid_q, out_valid_d;
    fetch_entry_t      out_q,       out_d;
    logic              imem_req_q,  imem_req_d;

    logic         skid_load;
    logic         skid_clear;
    logic         skid_full;
    fetch_entry_t skid_entry;
    fetch_entry_t mem_entry;

    assign mem_entry = '{instr: imem_rdata, pc: pc_q};

    fetch_skid_buffer u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .clear     (skid_clear),
        .in_entry  (mem_entry),
        .full      (skid_full),
        .out_entry (skid_entry)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        skid_load   = 1'b0;
        skid_clear  = 1'b0;

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
            end

            REQ: begin
                if (imem_ready) begin
                    pc_d = pc_next(pc_q);
                    if (!out_valid_q || !stall) begin
                        // Output register is free or being consumed this cycle.
                        out_d       = mem_entry;
                        out_valid_d = 1'b1;
                    end else begin
                        // Output is occupied and held: park the new word.
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end
                end else if (!stall) begin
                    // Current output consumed and nothing arrived: bubble.
                    out_valid_d = 1'b0;
                end
            end

            HOLD: begin
                // Only one instruction can be parked; no request is issued
                // until the skid entry has moved to the output register.
                if (!stall && skid_full) begin
                    out_d       = skid_entry;
                    out_valid_d = 1'b1;
                    skid_clear  = 1'b1;
                    state_d     = REQ;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Redirect overrides everything above: drop the output, drop the skid,
        // drop any word returned this cycle, and restart at the new address.
        // The output payload is left untouched so a discarded word never shows.
        if (redirect) begin
            out_d       = out_q;
            out_valid_d = 1'b0;
            skid_load   = 1'b0;
            skid_clear  = 1'b1;
            pc_d        = redirect_pc;
            state_d     = REQ;
        end

        imem_req_d = (state_d == REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            imem_req_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            imem_req_q  <= imem_req_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign if_valid    = out_valid_q;
    assign if_instr    = out_q.instr;
    assign if_pc       = out_q.pc;
    assign if_opcode   = opcode_of(out_q.instr);
    assign if_pc_plus2 = pc_next(out_q.pc);

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed sequence plus a pseudo-random stall/ready/redirect run for
// fetch_unit. A scoreboard queue receives {instr, pc} whenever the memory
// completes a request and is popped whenever decode consumes an instruction.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [15:0] RST_PC = 16'h0000;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [3:0]  if_opcode;
    logic [15:0] if_pc_plus2;
    logic [15:0] if_pc;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic [15:0] exp_addr;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_opcode   (if_opcode),
        .if_pc_plus2 (if_pc_plus2),
        .if_pc       (if_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Memory contents: a scrambled function of the address so every word
    // and every opcode field differs across nearby addresses.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[3:0], a[15:4]} ^ 16'h5A3C;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: settle, drive memory data, check the request address and any
    // consumed instruction, update the scoreboard, then advance past the edge.
    task automatic cycle();
        exp_t e;
        #1;
        imem_rdata = imem_ready ? mem_word(imem_addr) : 16'hDEAD;
        if (imem_req === 1'b1)
            check("imem_addr", imem_addr, exp_addr);
        if (!rst && if_valid === 1'b1 && !stall) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL sb_empty: observed pc %h expected no valid output", if_pc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("if_instr", if_instr, e.instr);
                check("if_pc", if_pc, e.pc);
                check("if_opcode", {12'h0, if_opcode}, {12'h0, e.instr[15:12]});
                check("if_pc_plus2", if_pc_plus2, e.pc + 16'd2);
            end
        end
        if (rst) begin
            sb.delete();
            exp_addr = RST_PC;
        end else if (redirect) begin
            sb.delete();
            exp_addr = redirect_pc;
        end else if (imem_req === 1'b1 && imem_ready) begin
            sb.push_back('{instr: mem_word(exp_addr), pc: exp_addr});
            exp_addr = exp_addr + 16'd2;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        imem_ready  = 1'b1;
        imem_rdata  = 16'h0000;
        exp_addr    = RST_PC;

        // Reset state
        cycle();
        cycle();
        check("rst_if_valid", {15'h0, if_valid}, 16'h0);
        check("rst_if_instr", if_instr, 16'h0000);
        check("rst_if_pc", if_pc, 16'h0000);
        check("rst_imem_req", {15'h0, imem_req}, 16'h0);

        // Start-up and back-to-back fetch
        rst = 1'b0;
        check("post_rst_req", {15'h0, imem_req}, 16'h0);
        cycle();
        check("start_req", {15'h0, imem_req}, 16'h1);
        check("start_addr", imem_addr, RST_PC);
        cycle();
        check("seq0_valid", {15'h0, if_valid}, 16'h1);
        check("seq0_pc", if_pc, 16'h0000);
        cycle();
        check("seq1_valid", {15'h0, if_valid}, 16'h1);
        check("seq1_pc", if_pc, 16'h0002);
        cycle();
        check("seq2_valid", {15'h0, if_valid}, 16'h1);
        check("seq2_pc", if_pc, 16'h0004);

        // Stall for three cycles with memory ready: skid then HOLD
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("hold_req", {15'h0, imem_req}, 16'h0);
            check("hold_pc", if_pc, 16'h0004);
            check("hold_instr", if_instr, mem_word(16'h0004));
        end
        stall = 1'b0;
        cycle();
        check("skid_out_valid", {15'h0, if_valid}, 16'h1);
        check("skid_out_pc", if_pc, 16'h0006);
        check("resume_req", {15'h0, imem_req}, 16'h1);
        check("resume_addr", imem_addr, 16'h0008);
        cycle();
        check("resume_pc", if_pc, 16'h0008);

        // Redirect concurrent with stall and a returning word
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        cycle();
        stall    = 1'b0;
        redirect = 1'b0;
        check("redir_valid", {15'h0, if_valid}, 16'h0);
        check("redir_addr", imem_addr, 16'h0040);
        check("redir_instr_kept", if_instr, mem_word(16'h0008));
        cycle();
        check("redir_tgt_valid", {15'h0, if_valid}, 16'h1);
        check("redir_tgt_pc", if_pc, 16'h0040);
        check("redir_tgt_instr", if_instr, mem_word(16'h0040));

        // Memory not ready for four cycles
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("wait_bubble", {15'h0, if_valid}, 16'h0);
            check("wait_addr", imem_addr, 16'h0042);
        end
        imem_ready = 1'b1;
        cycle();
        check("wait_done_valid", {15'h0, if_valid}, 16'h1);
        check("wait_done_pc", if_pc, 16'h0042);
        imem_ready = 1'b0;
        cycle();
        check("wait_single", {15'h0, if_valid}, 16'h0);
        imem_ready = 1'b1;

        // Address wrap at the top of memory
        redirect    = 1'b1;
        redirect_pc = 16'hFFFC;
        cycle();
        redirect = 1'b0;
        check("wrap_start", imem_addr, 16'hFFFC);
        cycle();
        cycle();
        check("wrap_pc", if_pc, 16'hFFFE);
        check("wrap_plus2", if_pc_plus2, 16'h0000);
        check("wrap_addr", imem_addr, 16'h0000);
        cycle();
        check("wrap_next_pc", if_pc, 16'h0000);

        // Reset in the middle of an accepted request
        check("mid_rst_req", {15'h0, imem_req}, 16'h1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mid_rst_valid", {15'h0, if_valid}, 16'h0);
        check("mid_rst_req_low", {15'h0, imem_req}, 16'h0);
        check("mid_rst_if_pc", if_pc, 16'h0000);
        check("mid_rst_instr", if_instr, 16'h0000);
        cycle();
        check("mid_rst_restart", imem_addr, RST_PC);
        check("mid_rst_req_hi", {15'h0, imem_req}, 16'h1);
        cycle();
        check("mid_rst_first", if_pc, RST_PC);

        // Pseudo-random stall / ready / redirect mix
        for (int i = 0; i < 400; i++) begin
            int r;
            r           = $urandom;
            stall       = ($urandom_range(0, 3) == 0);
            imem_ready  = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 24) == 0);
            redirect_pc = r[15:0] & 16'hFFFE;
            cycle();
        end
        stall      = 1'b0;
        redirect   = 1'b0;
        imem_ready = 1'b1;
        for (int i = 0; i < 6; i++)
            cycle();
        check("drain_valid", {15'h0, if_valid}, 16'h1);
        check("drain_depth", 16'(sb.size()), 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning first instruction address after reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port imem_req, output, 1 bit: instruction memory read request.
REQ-005 SHALL have port imem_addr, output, 16 bits: byte address of the requested instruction.
REQ-006 SHALL have port imem_ready, input, 1 bit: imem_rdata valid this cycle; completes the request.
REQ-007 SHALL have port imem_rdata, input, 16 bits: returned instruction.
REQ-008 SHALL have port stall, input, 1 bit: decode cannot accept; hold the output register.
REQ-009 SHALL have port redirect, input, 1 bit: branch/jump taken downstream.
REQ-010 SHALL have port redirect_pc, input, 16 bits: new fetch address, sampled when redirect=1.
REQ-011 SHALL have port if_valid, output, 1 bit: if_instr/if_pc hold a live instruction.
REQ-012 SHALL have port if_instr, output, 16 bits: fetched instruction to decode.
REQ-013 SHALL have port if_opcode, output, 4 bits: if_instr[15:12], feeds the control unit.
REQ-014 SHALL have port if_pc_plus2, output, 16 bits: if_pc+2, for branch/jump target computation.
REQ-015 SHALL have port if_pc, output, 16 bits: address of if_instr.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, HOLD.
REQ-017 IDLE: imem_req=0; SHALL go to REQ next cycle unconditionally.
REQ-018 REQ: imem_req=1, imem_addr=pc; addr SHALL stay stable until imem_ready or redirect.
REQ-019 In REQ with imem_ready=1 and (if_valid=0 or stall=0): SHALL load if_instr=imem_rdata, if_pc=pc, if_valid=1, pc=pc+2; stay REQ.
REQ-020 In REQ with imem_ready=1, if_valid=1, stall=1: SHALL store rdata/pc in skid buffer, pc=pc+2, go HOLD.
REQ-021 In REQ with imem_ready=0 and stall=0: SHALL clear if_valid (bubble); with stall=1 SHALL hold outputs.
REQ-022 HOLD: imem_req=0; when stall=0 SHALL move skid into output register (if_valid=1), go REQ.
REQ-023 redirect=1 SHALL take priority over stall and imem_ready: if_valid=0, skid discarded, pc=redirect_pc, next state REQ; rdata returned that cycle is discarded.
REQ-024 Memory SHALL accept an address change on imem_addr while imem_req=1 without imem_ready (abandoned request has no side effect).
REQ-025 pc arithmetic SHALL be 16-bit modulo: 16'hFFFE+2 wraps to 16'h0000.
REQ-026 Fetch-to-output latency SHALL be one clock after the imem_ready cycle; with zero-wait memory, sustained throughput is one instruction per cycle.
REQ-027 if_opcode and if_pc_plus2 SHALL be combinational from the output register.
REQ-028 No instruction SHALL be lost or duplicated across any stall/ready combination.

Reset
REQ-029 On rst=1 at a clock edge: state=IDLE, pc=RESET_PC, if_valid=0, skid empty, if_instr=0, if_pc=0.
REQ-030 During and one cycle after reset imem_req SHALL be 0; rst mid-request SHALL abandon the request and ignore any imem_ready.
REQ-031 rst SHALL override redirect, stall and imem_ready.

Structure
REQ-032 Shared package risc_pkg SHALL hold INSTR_W=16, ADDR_W=16, opcode constants (LW=0, SW=1, BEQ=11, BNE=12, J=13) and the fetch state enum.
REQ-033 Skid buffer (data, pc, full flag) SHALL be sub-module fetch_skid_buffer; remaining logic in fetch_unit.

Verification
REQ-034 Reset, RESET_PC=16'h0000, imem_ready=1 always, stall=0 -> imem_req rises cycle 2; if_pc 0000,0002,0004 on consecutive cycles, if_valid continuous.
REQ-035 Stall held 3 cycles while imem_ready=1 -> HOLD entered, imem_req=0, if_instr frozen; after release, skid instruction (next pc) emitted, then fetch resumes, no gap or duplicate.
REQ-036 redirect=1, redirect_pc=16'h0040 concurrent with stall=1 and imem_ready=1 -> if_valid=0 next cycle, imem_addr=0040, returned word never appears on if_instr.
REQ-037 imem_ready low 4 cycles -> imem_addr stable, if_valid=0 bubbles, single instruction emitted when ready arrives.
REQ-038 pc=16'hFFFE fetched -> next imem_addr=16'h0000.
REQ-039 rst asserted while imem_req=1, imem_ready pulsed same cycle -> if_valid=0, pc=RESET_PC, data discarded.
